cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Transmit end of the Common Data Bus. Collects completed results from the
//  functional units (ALUs fed by rs0-rs3, plus the load unit), buffers them per
//  source, and broadcasts exactly one result per cycle as a CDB_packet_t.
//  The output feeds the reservation stations, the ROB and the register status.
//  Round-robin arbitration; flushed on misprediction.
// PARAMETERS
//  NUM_SRC  5   number of result sources (index 0-3 = ALU0-3, 4 = load unit)
//  DEPTH    2   entries in each per-source result FIFO (power of 2, >=2)
// PORTS
//  clk            in   1            clock
//  reset          in   1            synchronous, active-high reset
//  mispredicted   in   1            flush: discard all buffered results
//  fu_valid       in   NUM_SRC      source i presents a result this cycle
//  fu_rob_entry   in   NUM_SRC*4    ROB tag of source i, slice [4i+3:4i]
//  fu_result      in   NUM_SRC*32   result value of source i, slice [32i+31:32i]
//  fu_load_step1  in   NUM_SRC      result is load address phase, not final data
//  fu_ready       out  NUM_SRC      FIFO i can accept a result this cycle
//  cdb_out        out  CDB_packet_t broadcast {dest_ROB_entry, result, load_step1}
//  cdb_src        out  3            index of source broadcast this cycle (debug)
// BEHAVIOUR
//  - Reset/flush: on a clk edge with reset | mispredicted, all FIFOs empty,
//    RR pointer = NUM_SRC-1, cdb_out all-zero (dest_ROB_entry 0 = idle),
//    cdb_src 0. Inputs presented in that cycle are dropped.
//  - Idle encoding: dest_ROB_entry == 4'b0 means no broadcast; result and
//    load_step1 are 0 when idle. Any other CDB_packet_t fields are always 0.
//  - fu_ready[i] = (count_i < DEPTH); a function of registered state only, no
//    combinational path from fu_valid. A full FIFO stays not-ready even
//    when it is popped in the same cycle.
//  - Push: fu_valid[i] & fu_ready[i] & (fu_rob_entry_i != 0) writes
//    {rob, result, load_step1} to the tail of FIFO i. A valid with tag 0 is
//    illegal and is dropped without a push.
//  - Arbitration, every cycle: starting at (ptr+1) mod NUM_SRC, scan upward
//    with wrap; the first non-empty FIFO wins. Only FIFO state from before the
//    edge counts: a result pushed this cycle cannot win until the next cycle.
//  - Grant: the winner's head is popped, registered into cdb_out and cdb_src at
//    the edge, and ptr <= winner. No winner: cdb_out <= idle, ptr unchanged.
//  - Latency: a result accepted at edge N appears on cdb_out after edge N+1
//    at the earliest; it is held for exactly one cycle.
//  - Throughput: one broadcast per cycle; each source receives at least one
//    grant in any NUM_SRC consecutive cycles while it is non-empty.
//  - Per-source order is FIFO; no ordering guarantee across sources.
//  - Simultaneous push and pop on the same non-full FIFO: both happen and the
//    count is unchanged. Pointer wrap: modulo DEPTH, no dead entries.
//  - Reset or flush during a cycle with a pending grant: the grant is
//    cancelled and cdb_out is idle next cycle.
// TESTING
//  1 reset, then fu_valid[0]=1 rob=3 res=0xDEADBEEF for 1 cycle -> cdb_out
//    {3,0xDEADBEEF,0} exactly one cycle, two edges after input; idle after.
//  2 all 5 sources push (rob 1..5) in the same cycle -> broadcasts rob 1,2,3,4,5
//    on 5 consecutive cycles (src 0..4), then idle.
//  3 source 2 pushes every cycle, others idle -> fu_ready[2] stays 1; CDB shows
//    one result per cycle, in order, with no drops.
//  4 source 1 pushes 2 with no grants (srcs 0 and 4 busy) -> fu_ready[1]=0;
//    a third push is held back until a pop; FIFO order holds.
//  5 3 FIFOs non-empty, mispredicted pulse -> next cycle cdb_out idle, all
//    fu_ready=1, no stale tag ever broadcast.
//  6 load unit pushes rob=7 with load_step1=1 -> cdb_out {7,addr,1}, src=4;
//    fu_valid with rob=0 -> nothing broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs with round-robin broadcast of one {rob, result, load_step1} per cycle
module cdb_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mispredicted,
  input  logic [NUM_SRC-1:0]      fu_valid,
  input  logic [NUM_SRC*4-1:0]    fu_rob_entry,
  input  logic [NUM_SRC*32-1:0]   fu_result,
  input  logic [NUM_SRC-1:0]      fu_load_step1,
  output logic [NUM_SRC-1:0]      fu_ready,
  output logic [36:0]             cdb_out,
  output logic [2:0]              cdb_src
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [36:0] mem [NUM_SRC][DEPTH];
  logic [AW-1:0] head [NUM_SRC];
  logic [AW-1:0] tail [NUM_SRC];
  logic [CW-1:0] count [NUM_SRC];
  logic [2:0] ptr;
  logic [2:0] win;
  logic found;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  int j;
  // Scan from ptr+1 with wrap; only pre-edge occupancy is visible, so same-cycle pushes cannot win
  always_comb begin
    found = 1'b0;
    win = '0;
    j = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && count[j] != '0) begin
        found = 1'b1;
        win = 3'(j);
      end
    end
  end
  // Ready depends on count alone, so a full FIFO stays blocked even while it is being popped
  always_comb begin
    fu_ready = '0;
    push = '0;
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fu_ready[i] = count[i] < CW'(DEPTH);
      push[i] = fu_valid[i] & fu_ready[i] & (|fu_rob_entry[4*i+:4]);
      pop[i] = found && (win == 3'(i));
    end
  end
  always_ff @(posedge clk) begin
    if (reset | mispredicted) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
        count[i] <= '0;
      end
      ptr <= 3'(NUM_SRC - 1);
      cdb_out <= '0;
      cdb_src <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          mem[i][tail[i]] <= {fu_rob_entry[4*i+:4], fu_result[32*i+:32], fu_load_step1[i]};
          tail[i] <= tail[i] + 1'b1;
        end
        if (pop[i]) head[i] <= head[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      cdb_out <= found ? mem[win][head[win]] : '0;
      cdb_src <= found ? win : '0;
      if (found) ptr <= win;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus random traffic against a queue-based model of the CDB arbiter
module tb_cdb_arbiter;
  localparam int N = 5;
  logic clk = 0;
  logic reset = 1;
  logic mispredicted = 0;
  logic [4:0] fu_valid = 0;
  logic [4:0] fu_load_step1 = 0;
  logic [4:0] fu_ready;
  logic [19:0] fu_rob_entry = 0;
  logic [159:0] fu_result = 0;
  logic [36:0] cdb_out;
  logic [2:0] cdb_src;
  int checks = 0;
  int errors = 0;
  logic [36:0] q [N][$];
  int mptr = 4;
  logic [36:0] exp_out = 0;
  logic [2:0] exp_src = 0;
  logic [4:0] exp_ready = 5'h1f;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .mispredicted(mispredicted), .fu_valid(fu_valid),
    .fu_rob_entry(fu_rob_entry), .fu_result(fu_result), .fu_load_step1(fu_load_step1),
    .fu_ready(fu_ready), .cdb_out(cdb_out), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    fu_valid = 0; fu_rob_entry = 0; fu_result = 0; fu_load_step1 = 0;
    mispredicted = 0; reset = 0;
  endtask

  task automatic set_src(input int i, input logic [3:0] rob, input logic [31:0] res, input logic ls);
    fu_valid[i] = 1'b1;
    fu_rob_entry[4*i+:4] = rob;
    fu_result[32*i+:32] = res;
    fu_load_step1[i] = ls;
  endtask

  // Advance one edge; the model applies the rules to queues using the inputs seen at that edge
  task automatic tick();
    int w;
    logic [4:0] rdy;
    @(posedge clk);
    if (reset || mispredicted) begin
      for (int i = 0; i < N; i++) q[i].delete();
      mptr = 4; exp_out = 0; exp_src = 0;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && q[(mptr + k) % N].size() != 0) w = (mptr + k) % N;
      for (int i = 0; i < N; i++) rdy[i] = q[i].size() < 2;
      if (w >= 0) begin
        exp_out = q[w].pop_front(); exp_src = 3'(w); mptr = w;
      end else begin
        exp_out = 0; exp_src = 0;
      end
      for (int i = 0; i < N; i++)
        if (fu_valid[i] && rdy[i] && fu_rob_entry[4*i+:4] != 0)
          q[i].push_back({fu_rob_entry[4*i+:4], fu_result[32*i+:32], fu_load_step1[i]});
    end
    for (int i = 0; i < N; i++) exp_ready[i] = q[i].size() < 2;
    #1;
  endtask

  task automatic do_reset();
    clear_in(); reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0;
    checks++; if (cdb_out !== 37'h0) begin errors++; $display("FAIL reset_cdb got %h want 0", cdb_out); end
    checks++; if (cdb_src !== 3'd0) begin errors++; $display("FAIL reset_src got %0d want 0", cdb_src); end
    checks++; if (fu_ready !== 5'h1f) begin errors++; $display("FAIL reset_ready got %b want 11111", fu_ready); end
  endtask

  task automatic test_single();
    logic [36:0] want;
    do_reset();
    set_src(0, 4'd3, 32'hDEADBEEF, 1'b0); tick(); clear_in();
    for (int t = 0; t < 4; t++) begin
      if (t > 0) tick();
      want = (t == 1) ? {4'd3, 32'hDEADBEEF, 1'b0} : 37'h0;
      checks++; if (cdb_out !== want) begin errors++; $display("FAIL single t=%0d got %h want %h", t, cdb_out, want); end
      checks++; if ({cdb_out, cdb_src, fu_ready} !== {exp_out, exp_src, exp_ready})
        begin errors++; $display("FAIL single_model got %h/%0d/%b want %h/%0d/%b", cdb_out, cdb_src, fu_ready, exp_out, exp_src, exp_ready); end
    end
  endtask

  task automatic test_all_push();
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 4'(i + 1), $urandom, 1'b0);
    tick(); clear_in();
    for (int t = 0; t < 7; t++) begin
      if (t > 0) tick();
      checks++; if (cdb_out[36:33] !== ((t >= 1 && t <= 5) ? 4'(t) : 4'd0))
        begin errors++; $display("FAIL all_push_rob t=%0d got %0d", t, cdb_out[36:33]); end
      if (t >= 1 && t <= 5) begin
        checks++; if (cdb_src !== 3'(t - 1)) begin errors++; $display("FAIL all_push_src t=%0d got %0d want %0d", t, cdb_src, t - 1); end
      end
      checks++; if ({cdb_out, cdb_src, fu_ready} !== {exp_out, exp_src, exp_ready})
        begin errors++; $display("FAIL all_push_model got %h/%0d/%b want %h/%0d/%b", cdb_out, cdb_src, fu_ready, exp_out, exp_src, exp_ready); end
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int t = 0; t < 27; t++) begin
      clear_in();
      if (t < 24) set_src(2, 4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)));
      tick();
      checks++; if (fu_ready[2] !== 1'b1) begin errors++; $display("FAIL stream_ready t=%0d got %b want 1", t, fu_ready[2]); end
      checks++; if ({cdb_out, cdb_src, fu_ready} !== {exp_out, exp_src, exp_ready})
        begin errors++; $display("FAIL stream_model t=%0d got %h want %h", t, cdb_out, exp_out); end
    end
    clear_in();
  endtask

  task automatic test_full();
    do_reset();
    set_src(0, 4'd1, $urandom, 1'b0); set_src(1, 4'd2, $urandom, 1'b0); set_src(4, 4'd3, $urandom, 1'b0);
    tick();
    set_src(0, 4'd5, $urandom, 1'b0); set_src(1, 4'd4, $urandom, 1'b0); set_src(4, 4'd6, $urandom, 1'b0);
    tick();
    checks++; if (fu_ready[1] !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fu_ready[1]); end
    checks++; if (cdb_out[36:33] !== 4'd1) begin errors++; $display("FAIL full_first got %0d want 1", cdb_out[36:33]); end
    clear_in(); set_src(1, 4'd7, $urandom, 1'b0);
    tick();
    checks++; if (cdb_out[36:33] !== 4'd2 || cdb_src !== 3'd1)
      begin errors++; $display("FAIL full_second got %0d/%0d want 2/1", cdb_out[36:33], cdb_src); end
    for (int t = 0; t < 10; t++) begin
      if (t == 1) clear_in();
      tick();
      checks++; if ({cdb_out, cdb_src, fu_ready} !== {exp_out, exp_src, exp_ready})
        begin errors++; $display("FAIL full_model t=%0d got %h/%0d/%b want %h/%0d/%b", t, cdb_out, cdb_src, fu_ready, exp_out, exp_src, exp_ready); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_src(0, 4'd1, $urandom, 1'b0); set_src(2, 4'd2, $urandom, 1'b0); set_src(3, 4'd3, $urandom, 1'b0);
    tick(); clear_in();
    mispredicted = 1; set_src(1, 4'd5, $urandom, 1'b0);
    tick(); clear_in();
    checks++; if (fu_ready !== 5'h1f) begin errors++; $display("FAIL flush_ready got %b want 11111", fu_ready); end
    for (int t = 0; t < 5; t++) begin
      if (t > 0) tick();
      checks++; if (cdb_out !== 37'h0) begin errors++; $display("FAIL flush_idle t=%0d got %h want 0", t, cdb_out); end
    end
  endtask

  task automatic test_load();
    logic [31:0] addr;
    addr = $urandom;
    do_reset();
    set_src(4, 4'd7, addr, 1'b1); tick(); clear_in();
    tick();
    checks++; if (cdb_out !== {4'd7, addr, 1'b1}) begin errors++; $display("FAIL load_pkt got %h want %h", cdb_out, {4'd7, addr, 1'b1}); end
    checks++; if (cdb_src !== 3'd4) begin errors++; $display("FAIL load_src got %0d want 4", cdb_src); end
    set_src(3, 4'd0, $urandom, 1'b1); tick(); clear_in();
    for (int t = 0; t < 2; t++) begin
      if (t > 0) tick();
      checks++; if (cdb_out !== 37'h0) begin errors++; $display("FAIL tag0_idle t=%0d got %h want 0", t, cdb_out); end
    end
    checks++; if (fu_ready !== 5'h1f) begin errors++; $display("FAIL tag0_ready got %b want 11111", fu_ready); end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      clear_in();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) != 0) set_src(i, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
      mispredicted = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 79) == 0);
      tick();
      checks++; if ({cdb_out, cdb_src, fu_ready} !== {exp_out, exp_src, exp_ready})
        begin errors++; $display("FAIL random t=%0d got %h/%0d/%b want %h/%0d/%b", t, cdb_out, cdb_src, fu_ready, exp_out, exp_src, exp_ready); end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_push();
    test_stream();
    test_full();
    test_flush();
    test_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
